id_stage_pipe_param: RTL and testbench



---
 rtl/id_stage_pipe_param_if.sv | 72 +++++++
 rtl/id_stage_pipe_param.sv | 163 ++++++++++++++++
 tb/tb_id_stage_pipe_param.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_param_if.sv
// Bundle of ID-stage signals: pre-decoded instruction in, write-back in,
// ID/EX pipeline register out, plus the load-use stall request.
//
// Handshake: valid_i marks a real instruction in IF/ID. hazard_o is the only
// back-pressure. While hazard_o=1 or busywait_i=1 the source must keep
// presenting the same instruction. The stage issues it on the first edge
// where neither stall is active. flush_i kills the instruction at the edge
// unless busywait_i holds the stage; in that case the flush must be
// re-presented afterwards.
interface id_stage_pipe_param_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 16
);
    localparam int RAW = $clog2(NREG);

    // decoded instruction from IF/ID
    logic              valid_i;
    logic [29:0]       pc_i;
    logic [RAW-1:0]    rs1_i;
    logic [RAW-1:0]    rs2_i;
    logic [RAW-1:0]    rd_i;
    logic              rs1_used_i;
    logic              rs2_used_i;
    logic              reg_wr_en_i;
    logic              is_load_i;
    logic              is_store_i;
    logic              is_branch_i;
    logic [XLEN-1:0]   imm_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              busywait_i;
    logic              flush_i;

    // write-back port
    logic              wb_en_i;
    logic [RAW-1:0]    wb_addr_i;
    logic [XLEN-1:0]   wb_data_i;

    // stall request and ID/EX register
    logic              hazard_o;
    logic              valid_o;
    logic [29:0]       pc_o;
    logic [XLEN-1:0]   rs1_val_o;
    logic [XLEN-1:0]   rs2_val_o;
    logic [XLEN-1:0]   imm_o;
    logic [RAW-1:0]    rs1_o;
    logic [RAW-1:0]    rs2_o;
    logic [RAW-1:0]    rd_o;
    logic              reg_wr_en_o;
    logic              is_load_o;
    logic              is_store_o;
    logic              is_branch_o;
    logic [CTRL_W-1:0] ctrl_o;

    modport master (
        output valid_i, pc_i, rs1_i, rs2_i, rd_i, rs1_used_i, rs2_used_i,
               reg_wr_en_i, is_load_i, is_store_i, is_branch_i, imm_i, ctrl_i,
               busywait_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        input  hazard_o, valid_o, pc_o, rs1_val_o, rs2_val_o, imm_o,
               rs1_o, rs2_o, rd_o, reg_wr_en_o, is_load_o, is_store_o,
               is_branch_o, ctrl_o
    );

    modport slave (
        input  valid_i, pc_i, rs1_i, rs2_i, rd_i, rs1_used_i, rs2_used_i,
               reg_wr_en_i, is_load_i, is_store_i, is_branch_i, imm_i, ctrl_i,
               busywait_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        output hazard_o, valid_o, pc_o, rs1_val_o, rs2_val_o, imm_o,
               rs1_o, rs2_o, rd_o, reg_wr_en_o, is_load_o, is_store_o,
               is_branch_o, ctrl_o
    );
endinterface

// File: rtl/id_stage_pipe_param.sv
// Decode-stage datapath: register file with write-through bypass, load-use
// scoreboard sized by LOAD_LAT, and the ID/EX register with hold/flush/bubble.
module id_stage_pipe_param #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int CTRL_W   = 16,
    parameter int LOAD_LAT = 1
) (
    input logic clk_i,
    input logic rst_i,
    id_stage_pipe_param_if.slave bus
);
    localparam int RAW = $clog2(NREG);

    typedef struct packed {
        logic              valid;
        logic [29:0]       pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [RAW-1:0]    rs1;
        logic [RAW-1:0]    rs2;
        logic [RAW-1:0]    rd;
        logic              reg_wr_en;
        logic              is_load;
        logic              is_store;
        logic              is_branch;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_en_i && (bus.wb_addr_i != '0)) begin
            rf[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    // A write landing this cycle is forwarded so the reader never sees stale data.
    always_comb begin
        rs1_val = rf[bus.rs1_i];
        rs2_val = rf[bus.rs2_i];
        if (bus.rs1_i == '0) begin
            rs1_val = '0;
        end else if (bus.wb_en_i && (bus.wb_addr_i == bus.rs1_i)) begin
            rs1_val = bus.wb_data_i;
        end
        if (bus.rs2_i == '0) begin
            rs2_val = '0;
        end else if (bus.wb_en_i && (bus.wb_addr_i == bus.rs2_i)) begin
            rs2_val = bus.wb_data_i;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    idex_t idex_q;
    idex_t idex_cap;
    logic  hazard;
    logic  issue;

    always_comb begin
        idex_cap           = '0;
        idex_cap.valid     = 1'b1;
        idex_cap.pc        = bus.pc_i;
        idex_cap.rs1_val   = rs1_val;
        idex_cap.rs2_val   = rs2_val;
        idex_cap.imm       = bus.imm_i;
        idex_cap.rs1       = bus.rs1_i;
        idex_cap.rs2       = bus.rs2_i;
        idex_cap.rd        = bus.rd_i;
        idex_cap.reg_wr_en = bus.reg_wr_en_i;
        idex_cap.is_load   = bus.is_load_i;
        idex_cap.is_store  = bus.is_store_i;
        idex_cap.is_branch = bus.is_branch_i;
        idex_cap.ctrl      = bus.ctrl_i;
    end

    assign issue = bus.valid_i && !bus.flush_i && !hazard;

    // Hold beats flush; a bubble is an all-zero register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_q <= '0;
        end else if (!bus.busywait_i) begin
            idex_q <= issue ? idex_cap : '0;
        end
    end

    assign bus.valid_o     = idex_q.valid;
    assign bus.pc_o        = idex_q.pc;
    assign bus.rs1_val_o   = idex_q.rs1_val;
    assign bus.rs2_val_o   = idex_q.rs2_val;
    assign bus.imm_o       = idex_q.imm;
    assign bus.rs1_o       = idex_q.rs1;
    assign bus.rs2_o       = idex_q.rs2;
    assign bus.rd_o        = idex_q.rd;
    assign bus.reg_wr_en_o = idex_q.reg_wr_en;
    assign bus.is_load_o   = idex_q.is_load;
    assign bus.is_store_o  = idex_q.is_store;
    assign bus.is_branch_o = idex_q.is_branch;
    assign bus.ctrl_o      = idex_q.ctrl;

    // ------------------------------------------------------------------
    // Load-use scoreboard: slot 0 is the load sitting in ID/EX, older slots
    // track it through the remaining load latency.
    // ------------------------------------------------------------------
    logic [LOAD_LAT-1:0]          slot_valid;
    logic [LOAD_LAT-1:0][RAW-1:0] slot_rd;

    assign slot_valid[0] = idex_q.valid && idex_q.is_load && (idex_q.rd != '0);
    assign slot_rd[0]    = idex_q.rd;

    if (LOAD_LAT > 1) begin : g_shift
        logic [LOAD_LAT-1:1]          sh_valid;
        logic [LOAD_LAT-1:1][RAW-1:0] sh_rd;

        // Flush does not touch these: the loads here predate the flushed instruction.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sh_valid <= '0;
                sh_rd    <= '0;
            end else if (!bus.busywait_i) begin
                for (int k = 1; k < LOAD_LAT; k++) begin
                    sh_valid[k] <= slot_valid[k-1];
                    sh_rd[k]    <= slot_rd[k-1];
                end
            end
        end

        for (genvar k = 1; k < LOAD_LAT; k++) begin : g_slot
            assign slot_valid[k] = sh_valid[k];
            assign slot_rd[k]    = sh_rd[k];
        end
    end

    // x0 never matches because a slot is only valid for rd != 0.
    logic slot_match;

    always_comb begin
        slot_match = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (slot_valid[k] &&
                ((bus.rs1_used_i && (bus.rs1_i == slot_rd[k])) ||
                 (bus.rs2_used_i && (bus.rs2_i == slot_rd[k])))) begin
                slot_match = 1'b1;
            end
        end
    end

    assign hazard       = bus.valid_i && !bus.flush_i && slot_match;
    assign bus.hazard_o = hazard;
endmodule

// File: tb/tb_id_stage_pipe_param.sv
// Directed bench for id_stage_pipe_param: one instance with LOAD_LAT=1 and one
// with LOAD_LAT=3 share stimulus; a selector picks which one is being checked.
module tb_id_stage_pipe_param;
  localparam int W = 162;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic        valid, rs1_used, rs2_used, wr_en, is_load, is_store, is_branch;
  logic [29:0] pc;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [15:0] ctrl;
  logic        busy, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sel3;

  id_stage_pipe_param_if #(.XLEN(32), .NREG(32), .CTRL_W(16)) bus1 ();
  id_stage_pipe_param_if #(.XLEN(32), .NREG(32), .CTRL_W(16)) bus3 ();

  assign bus1.valid_i = valid;       assign bus3.valid_i = valid;
  assign bus1.pc_i = pc;             assign bus3.pc_i = pc;
  assign bus1.rs1_i = rs1;           assign bus3.rs1_i = rs1;
  assign bus1.rs2_i = rs2;           assign bus3.rs2_i = rs2;
  assign bus1.rd_i = rd;             assign bus3.rd_i = rd;
  assign bus1.rs1_used_i = rs1_used; assign bus3.rs1_used_i = rs1_used;
  assign bus1.rs2_used_i = rs2_used; assign bus3.rs2_used_i = rs2_used;
  assign bus1.reg_wr_en_i = wr_en;   assign bus3.reg_wr_en_i = wr_en;
  assign bus1.is_load_i = is_load;   assign bus3.is_load_i = is_load;
  assign bus1.is_store_i = is_store; assign bus3.is_store_i = is_store;
  assign bus1.is_branch_i = is_branch; assign bus3.is_branch_i = is_branch;
  assign bus1.imm_i = imm;           assign bus3.imm_i = imm;
  assign bus1.ctrl_i = ctrl;         assign bus3.ctrl_i = ctrl;
  assign bus1.busywait_i = busy;     assign bus3.busywait_i = busy;
  assign bus1.flush_i = flush;       assign bus3.flush_i = flush;
  assign bus1.wb_en_i = wb_en;       assign bus3.wb_en_i = wb_en;
  assign bus1.wb_addr_i = wb_addr;   assign bus3.wb_addr_i = wb_addr;
  assign bus1.wb_data_i = wb_data;   assign bus3.wb_data_i = wb_data;

  id_stage_pipe_param #(.XLEN(32), .NREG(32), .CTRL_W(16), .LOAD_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.slave)
  );
  id_stage_pipe_param #(.XLEN(32), .NREG(32), .CTRL_W(16), .LOAD_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3.slave)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_e;
  logic [31:0]  ref_rf[32];
  int           n_assert = 0;
  int           n_fail = 0;

  function automatic logic [W-1:0] pack_out(input logic s3);
    if (s3)
      return {bus3.valid_o, bus3.pc_o, bus3.rs1_val_o, bus3.rs2_val_o, bus3.imm_o,
              bus3.rs1_o, bus3.rs2_o, bus3.rd_o, bus3.reg_wr_en_o, bus3.is_load_o,
              bus3.is_store_o, bus3.is_branch_o, bus3.ctrl_o};
    return {bus1.valid_o, bus1.pc_o, bus1.rs1_val_o, bus1.rs2_val_o, bus1.imm_o,
            bus1.rs1_o, bus1.rs2_o, bus1.rd_o, bus1.reg_wr_en_o, bus1.is_load_o,
            bus1.is_store_o, bus1.is_branch_o, bus1.ctrl_o};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return ref_rf[a];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic u1, input logic u2, input logic wr, input logic ld,
                       input logic [31:0] im);
    valid = 1'b1; pc = pc + 30'd1;
    rs1 = a; rs2 = b; rd = d; rs1_used = u1; rs2_used = u2;
    wr_en = wr; is_load = ld;
    is_store = ld ? 1'b0 : 1'($urandom_range(0, 1));
    is_branch = ld ? 1'b0 : 1'($urandom_range(0, 1));
    imm = im; ctrl = 16'($urandom_range(1, 65535));
  endtask

  task automatic idle();
    valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    wr_en = 1'b0; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
    imm = '0; ctrl = '0;
  endtask

  task automatic wb_set(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  // Called at a negedge with inputs already set: checks hazard, predicts the
  // ID/EX content after the next edge, then compares it at the following negedge.
  task automatic step(input logic exp_haz, input string tag);
    logic [W-1:0] e;
    #1;
    check({tag, "_haz"}, W'(sel3 ? bus3.hazard_o : bus1.hazard_o), W'(exp_haz));
    if (busy) e = last_e;
    else if (flush || exp_haz || !valid) e = '0;
    else e = {1'b1, pc, ref_rd(rs1), ref_rd(rs2), imm, rs1, rs2, rd,
              wr_en, is_load, is_store, is_branch, ctrl};
    exp_q.push_back(e);
    last_e = e;
    if (wb_en && wb_addr != 5'd0) ref_rf[wb_addr] = wb_data;
    @(negedge clk);
    check(tag, pack_out(sel3), exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    last_e = '0; pc = '0; sel3 = 1'b0;
    busy = 1'b0; flush = 1'b0;
    idle();
    wb_set(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_l1", pack_out(1'b0), '0);
    check("reset_out_l3", pack_out(1'b1), '0);
    check("reset_haz", W'(bus1.hazard_o | bus3.hazard_o), '0);
    @(negedge clk);

    // ---- register file, x0, bypass (LOAD_LAT=1 instance) ----
    wb_set(1'b1, 5'd5, 32'hDEADBEEF); step(1'b0, "wb_x5");
    wb_set(1'b1, 5'd0, 32'h1234);     step(1'b0, "wb_x0");
    wb_set(1'b0, 5'd0, 32'd0);
    instr(5'd5, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11); step(1'b0, "read_x5_x0");
    wb_set(1'b1, 5'd7, 32'h55);
    instr(5'd7, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h22); step(1'b0, "bypass_x7");
    wb_set(1'b0, 5'd0, 32'd0);
    instr(5'd0, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h33); step(1'b0, "read_x7");

    // ---- load-use, LOAD_LAT=1 ----
    instr(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4); step(1'b0, "lw_x3");
    instr(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); step(1'b1, "dep_stall");
    step(1'b0, "dep_issue");
    idle(); step(1'b0, "idle_a");
    instr(5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8); step(1'b0, "lw_x6");
    instr(5'd1, 5'd6, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0); step(1'b0, "unused_src");

    // ---- flush, busywait+flush ----
    instr(5'd7, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); flush = 1'b1; step(1'b0, "flush");
    flush = 1'b0;
    instr(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); step(1'b0, "lw_x8");
    instr(5'd8, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0); flush = 1'b1; step(1'b0, "flush_dep");
    flush = 1'b0;
    instr(5'd5, 5'd7, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h77); step(1'b0, "add_cap");
    instr(5'd7, 5'd7, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h88);
    busy = 1'b1; flush = 1'b1; step(1'b0, "busy_flush_hold");
    busy = 1'b0; flush = 1'b0; step(1'b0, "after_hold");

    // ---- write-back while stalled ----
    instr(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); step(1'b0, "lw_x9");
    instr(5'd9, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    wb_set(1'b1, 5'd9, 32'hABCD); step(1'b1, "wb_during_haz");
    wb_set(1'b0, 5'd0, 32'd0);    step(1'b0, "wb_new_value");

    // ---- LOAD_LAT=3 instance ----
    idle();
    sel3 = 1'b1;
    repeat (3) step(1'b0, "drain");
    instr(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); step(1'b0, "l3_lw_x3");
    instr(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, "l3_stall1"); step(1'b1, "l3_stall2"); step(1'b1, "l3_stall3");
    step(1'b0, "l3_issue");
    instr(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); step(1'b0, "l3_lw_b");
    instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); step(1'b0, "l3_indep");
    instr(5'd1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, "l3_gap_stall1"); step(1'b1, "l3_gap_stall2");
    step(1'b0, "l3_gap_issue");
    instr(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); step(1'b0, "l3_lw_x0");
    instr(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0); step(1'b0, "l3_use_x0");
    idle(); repeat (3) step(1'b0, "l3_drain");

    // ---- busywait in the middle of a hazard ----
    instr(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); step(1'b0, "bw_lw");
    instr(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0); step(1'b1, "bw_stall_pre");
    busy = 1'b1;
    repeat (4) step(1'b1, "bw_frozen");
    busy = 1'b0;
    step(1'b1, "bw_stall_post1"); step(1'b1, "bw_stall_post2");
    step(1'b0, "bw_issue");
    idle(); step(1'b0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
